keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/sync_edge.sv | 37 +++
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared state encodings, keypad geometry, key map and row helpers.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

    localparam int COLS_N = 4;
    localparam int ROWS_N = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Code map seen by the calculator entry/ALU logic.
    typedef enum logic [3:0] {
        KEY_0   = 4'd0,  KEY_1   = 4'd1,  KEY_2   = 4'd2,  KEY_3   = 4'd3,
        KEY_4   = 4'd4,  KEY_5   = 4'd5,  KEY_6   = 4'd6,  KEY_7   = 4'd7,
        KEY_8   = 4'd8,  KEY_9   = 4'd9,  KEY_ADD = 4'd10, KEY_SUB = 4'd11,
        KEY_MUL = 4'd12, KEY_DIV = 4'd13, KEY_EQ  = 4'd14, KEY_CLR = 4'd15
    } key_code_t;

    // True when exactly one active-low row is asserted; ghosting is rejected.
    function automatic logic single_low(input logic [ROWS_N-1:0] r);
        return ($countones(~r) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [ROWS_N-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS_N - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Two-flop synchroniser with a rising-edge detector per bit.
// Revision : 1.0
// ============================================================================
module sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign q    = r_sync;
    assign rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 keypad column scan, press/release debounce, one code per press.
// Revision : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int RELEASE_TICKS  = 2,
    parameter int CNT_W          = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Scan_clk,
    input  logic [ROWS_N-1:0] Rows,
    output logic [COLS_N-1:0] Cols,
    output logic [3:0]        Key_code,
    output logic              Key_valid,
    output logic              Key_held
);

    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] C_REL_LAST = CNT_W'(RELEASE_TICKS);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic [ROWS_N-1:0] w_rows_s;
    logic [ROWS_N-1:0] w_rows_rise_unused;
    logic              w_scan_s_unused;
    logic              w_tick;
    logic              w_hit;
    logic [1:0]        w_hit_row;

    sync_edge #(.WIDTH(ROWS_N)) u_rows_sync (
        .clk  (Clock),
        .rst  (Reset),
        .d    (Rows),
        .q    (w_rows_s),
        .rise (w_rows_rise_unused)
    );

    sync_edge #(.WIDTH(1)) u_scan_sync (
        .clk  (Clock),
        .rst  (Reset),
        .d    (Scan_clk),
        .q    (w_scan_s_unused),
        .rise (w_tick)
    );

    assign w_hit     = single_low(w_rows_s);
    assign w_hit_row = low_index(w_rows_s);

    state_t            r_state;
    logic [1:0]        r_col;
    logic [1:0]        r_cand_row;
    logic [1:0]        r_cand_col;
    logic [CNT_W-1:0]  r_deb_cnt;
    logic [CNT_W-1:0]  r_rel_cnt;
    logic [COLS_N-1:0] r_cols;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_key_held;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= SCAN;
            r_col       <= 2'd0;
            r_cand_row  <= 2'd0;
            r_cand_col  <= 2'd0;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_cols      <= 4'b1110;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            // Column drive lags col by one cycle so it is always glitch-free.
            r_cols      <= ~(4'b0001 << r_col);
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (w_tick) begin
                        if (w_hit) begin
                            r_cand_row <= w_hit_row;
                            r_cand_col <= r_col;
                            if (DEBOUNCE_TICKS == 1) begin
                                r_deb_cnt   <= '0;
                                r_key_code  <= {w_hit_row, r_col};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= PRESSED;
                            end else begin
                                r_deb_cnt <= C_ONE;
                                r_state   <= DEBOUNCE;
                            end
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_tick) begin
                        if (w_hit && (w_hit_row == r_cand_row)) begin
                            if (r_deb_cnt + C_ONE == C_DEB_LAST) begin
                                r_deb_cnt   <= '0;
                                r_key_code  <= {r_cand_row, r_cand_col};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= PRESSED;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + C_ONE;
                            end
                        end else begin
                            r_deb_cnt <= '0;
                            r_col     <= r_col + 2'd1;
                            r_state   <= SCAN;
                        end
                    end
                end
                PRESSED: begin
                    r_rel_cnt <= '0;
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (w_tick) begin
                        if (&w_rows_s) begin
                            if (r_rel_cnt + C_ONE == C_REL_LAST) begin
                                r_rel_cnt  <= '0;
                                r_key_held <= 1'b0;
                                r_col      <= r_col + 2'd1;
                                r_state    <= SCAN;
                            end else begin
                                r_rel_cnt <= r_rel_cnt + C_ONE;
                            end
                        end else begin
                            r_rel_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign Cols      = r_cols;
    assign Key_code  = r_key_code;
    assign Key_valid = r_key_valid;
    assign Key_held  = r_key_held;

endmodule
`default_nettype wire
